// File: rtl/fazyrv_timer_pkg.sv
// Shared constants for the FazyRV Wishbone machine timer: register word
// offsets, CTRL bit positions, prescaler width and a byte-lane merge helper.
package fazyrv_timer_pkg;

  localparam int DATA_W  = 32;
  localparam int PRESC_W = 16;

  localparam logic [2:0] MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMECMP_HI = 3'd3;
  localparam logic [2:0] CTRL        = 3'd4;
  localparam logic [2:0] PRESC       = 3'd5;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IRQEN = 1;

  // Replace only the byte lanes selected by be; other lanes keep cur.
  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0]   cur,
                                                 input logic [DATA_W-1:0]   wdat,
                                                 input logic [DATA_W/8-1:0] be);
    logic [DATA_W-1:0] r;
    r = cur;
    for (int i = 0; i < DATA_W/8; i++) begin
      if (be[i]) r[i*8 +: 8] = wdat[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/fazyrv_timer_presc.sv
// Prescaler for the machine timer: counts 0..presc_i and issues one tick per
// wrap. Only instantiated when FAZYRV_TIMER_PRESC_EN is defined.
module fazyrv_timer_presc
  import fazyrv_timer_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_in,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt;

  // >= keeps the counter from running away if it ever sits above presc_i
  assign tick_o = en_i & (cnt >= presc_i);

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (en_i) begin
      cnt <= tick_o ? '0 : cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/fazyrv_wb_timer.sv
// Wishbone classic machine timer (mtime/mtimecmp) driving the FazyRV timer irq.
// Optional prescaler register enabled by defining FAZYRV_TIMER_PRESC_EN.
module fazyrv_wb_timer
  import fazyrv_timer_pkg::*;
#(
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic        EN_RST  = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_be_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              tirq_o
);

  logic [63:0]       mtime, mtime_inc, mtime_nxt;
  logic [63:0]       mtimecmp;
  logic [1:0]        ctrl_r;
  logic [31:0]       shadow;
  logic [DATA_W-1:0] rdata;
  logic [2:0]        word;
  logic              accept, wr, rd, wr_mt, tick;
  logic              unused_adr;

  assign word       = wb_adr_i[4:2];
  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr         = accept & wb_we_i;
  assign rd         = accept & ~wb_we_i;
  assign wr_mt      = wr & (|wb_be_i);

`ifdef FAZYRV_TIMER_PRESC_EN
  logic [PRESC_W-1:0] presc_r;

  fazyrv_timer_presc u_presc (
    .clk_i   (clk_i),
    .rst_in  (rst_in),
    .en_i    (ctrl_r[CTRL_EN]),
    .clr_i   (wr && (word == PRESC)),
    .presc_i (presc_r),
    .tick_o  (tick)
  );

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      presc_r <= '0;
    end else if (wr && (word == PRESC)) begin
      if (wb_be_i[0]) presc_r[7:0]  <= wb_dat_i[7:0];
      if (wb_be_i[1]) presc_r[15:8] <= wb_dat_i[15:8];
    end
  end
`else
  assign tick = ctrl_r[CTRL_EN];
`endif

  // A software write to one half wins over the tick for that half and
  // suppresses the LO->HI carry; a HI write still lets LO count.
  always_comb begin
    mtime_inc = mtime + 64'd1;
    mtime_nxt = tick ? mtime_inc : mtime;
    if (wr_mt && (word == MTIME_LO)) begin
      mtime_nxt = {mtime[63:32], be_merge(mtime[31:0], wb_dat_i, wb_be_i)};
    end else if (wr_mt && (word == MTIME_HI)) begin
      mtime_nxt = {be_merge(mtime[63:32], wb_dat_i, wb_be_i),
                   tick ? mtime_inc[31:0] : mtime[31:0]};
    end
  end

  always_comb begin
    rdata = '0;
    case (word)
      MTIME_LO:    rdata = mtime[31:0];
      MTIME_HI:    rdata = shadow;
      MTIMECMP_LO: rdata = mtimecmp[31:0];
      MTIMECMP_HI: rdata = mtimecmp[63:32];
      CTRL:        rdata = {30'b0, ctrl_r};
`ifdef FAZYRV_TIMER_PRESC_EN
      PRESC:       rdata = {{(DATA_W-PRESC_W){1'b0}}, presc_r};
`endif
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      mtime    <= '0;
      mtimecmp <= CMP_RST;
      ctrl_r   <= {1'b0, EN_RST};
      shadow   <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      tirq_o   <= 1'b0;
    end else begin
      wb_ack_o <= accept;
      wb_dat_o <= rd ? rdata : '0;
      tirq_o   <= ctrl_r[CTRL_IRQEN] & (mtime >= mtimecmp);
      mtime    <= mtime_nxt;
      // LO read latches HI so a following HI read is coherent
      if (rd && (word == MTIME_LO)) shadow <= mtime[63:32];
      if (wr) begin
        case (word)
          MTIMECMP_LO: mtimecmp[31:0]  <= be_merge(mtimecmp[31:0], wb_dat_i, wb_be_i);
          MTIMECMP_HI: mtimecmp[63:32] <= be_merge(mtimecmp[63:32], wb_dat_i, wb_be_i);
          CTRL:        if (wb_be_i[0]) ctrl_r <= wb_dat_i[1:0];
          default:     ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fazyrv_wb_timer.sv
// Directed bench for fazyrv_wb_timer: register table plus counting, wrap,
// shadow, interrupt, handshake and reset corner sequences.
module tb_fazyrv_wb_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  be;
  logic [31:0] adr, wdat, rdat;
  logic        ack, tirq;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fazyrv_wb_timer dut (
    .clk_i    (clk),
    .rst_in   (rst_n),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_be_i  (be),
    .wb_adr_i (adr),
    .wb_dat_i (wdat),
    .wb_dat_o (rdat),
    .wb_ack_o (ack),
    .tirq_o   (tirq)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  be;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[27];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input logic [31:0] act,
                         input logic [31:0] lo, input logic [31:0] hi);
    nvec++;
    if ((act < lo) || (act > hi) || $isunknown(act)) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h..%h", nm, act, lo, hi);
    end
  endtask

  // Called at a negedge with ack low; returns at a negedge with ack low.
  task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, output logic [31:0] q, output logic k);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; be = b; wdat = d;
    @(posedge clk);
    @(negedge clk);
    k = ack; q = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q; logic k;
    bus(1'b1, a, 4'hF, d, q, k);
    chk("write_ack", {31'b0, k}, 32'd1);
  endtask

  task automatic rd32(input logic [31:0] a, output logic [31:0] q);
    logic k;
    bus(1'b0, a, 4'h0, 32'h0, q, k);
    chk("read_ack", {31'b0, k}, 32'd1);
  endtask

  initial begin
    logic [31:0] q;
    logic        k;

    tbl[0]  = '{1'b0, 32'h00, 4'h0, 32'h0,         32'h0};
    tbl[1]  = '{1'b0, 32'h04, 4'h0, 32'h0,         32'h0};
    tbl[2]  = '{1'b0, 32'h08, 4'h0, 32'h0,         32'hFFFF_FFFF};
    tbl[3]  = '{1'b0, 32'h0C, 4'h0, 32'h0,         32'hFFFF_FFFF};
    tbl[4]  = '{1'b0, 32'h10, 4'h0, 32'h0,         32'h0};
    tbl[5]  = '{1'b1, 32'h08, 4'h2, 32'hAABB_CCDD, 32'h0};
    tbl[6]  = '{1'b0, 32'h08, 4'h0, 32'h0,         32'hFFFF_CCFF};
    tbl[7]  = '{1'b1, 32'h0C, 4'hF, 32'h1234_5678, 32'h0};
    tbl[8]  = '{1'b0, 32'h0C, 4'h0, 32'h0,         32'h1234_5678};
    tbl[9]  = '{1'b1, 32'h0C, 4'h0, 32'h0,         32'h0};
    tbl[10] = '{1'b0, 32'h0C, 4'h0, 32'h0,         32'h1234_5678};
    tbl[11] = '{1'b1, 32'h00, 4'hF, 32'h0000_0055, 32'h0};
    tbl[12] = '{1'b0, 32'h00, 4'h0, 32'h0,         32'h0000_0055};
    tbl[13] = '{1'b1, 32'h04, 4'hC, 32'hABCD_EF01, 32'h0};
    tbl[14] = '{1'b0, 32'h00, 4'h0, 32'h0,         32'h0000_0055};
    tbl[15] = '{1'b0, 32'h04, 4'h0, 32'h0,         32'hABCD_0000};
    tbl[16] = '{1'b0, 32'h18, 4'h0, 32'h0,         32'h0};
    tbl[17] = '{1'b1, 32'h1C, 4'hF, 32'hFFFF_FFFF, 32'h0};
    tbl[18] = '{1'b0, 32'h1C, 4'h0, 32'h0,         32'h0};
    tbl[19] = '{1'b1, 32'h14, 4'hF, 32'h0000_0003, 32'h0};
`ifdef FAZYRV_TIMER_PRESC_EN
    tbl[20] = '{1'b0, 32'h14, 4'h0, 32'h0,         32'h0000_0003};
`else
    tbl[20] = '{1'b0, 32'h14, 4'h0, 32'h0,         32'h0};
`endif
    tbl[21] = '{1'b0, 32'hFFFF_FFE8, 4'h0, 32'h0,  32'hFFFF_CCFF};
    tbl[22] = '{1'b1, 32'h10, 4'hF, 32'h0000_0002, 32'h0};
    tbl[23] = '{1'b0, 32'h10, 4'h0, 32'h0,         32'h0000_0002};
    tbl[24] = '{1'b1, 32'h10, 4'hF, 32'h0,         32'h0};
    tbl[25] = '{1'b0, 32'h10, 4'h0, 32'h0,         32'h0};
    tbl[26] = '{1'b1, 32'h14, 4'hF, 32'h0,         32'h0};

    cyc = 1'b0; stb = 1'b0; we = 1'b0; be = 4'h0; adr = '0; wdat = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack",  {31'b0, ack},  32'd0);
    chk("rst_dat",  rdat,          32'd0);
    chk("rst_tirq", {31'b0, tirq}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Register table with the counter stopped
    for (int i = 0; i < 27; i++) begin
      bus(tbl[i].we, tbl[i].adr, tbl[i].be, tbl[i].dat, q, k);
      chk($sformatf("tbl%0d_ack", i), {31'b0, k}, 32'd1);
      chk($sformatf("tbl%0d_dat", i), q, tbl[i].exp);
    end

    // Counting from zero after enabling
    wr32(32'h00, 32'h0);
    wr32(32'h04, 32'h0);
    wr32(32'h10, 32'h1);
    repeat (9) @(negedge clk);
    rd32(32'h00, q);
    chk_rng("count_lo", q, 32'd9, 32'd11);
    rd32(32'h04, q);
    chk("count_hi", q, 32'd0);

    // LO wrap carries into HI
    wr32(32'h04, 32'h0);
    wr32(32'h00, 32'hFFFF_FFFF);
    rd32(32'h00, q);
    chk_rng("wrap_lo", q, 32'd0, 32'd4);
    rd32(32'h04, q);
    chk("wrap_hi", q, 32'd1);

    // Shadow keeps HI coherent with the earlier LO read across a carry
    wr32(32'h10, 32'h0);
    wr32(32'h04, 32'h1);
    wr32(32'h00, 32'hFFFF_FFFF);
    rd32(32'h00, q);
    chk("shadow_lo", q, 32'hFFFF_FFFF);
    wr32(32'h10, 32'h1);
    repeat (3) @(negedge clk);
    rd32(32'h04, q);
    chk("shadow_hi", q, 32'd1);
    rd32(32'h00, q);
    rd32(32'h04, q);
    chk("shadow_hi_new", q, 32'd2);

    // Reset in the middle of an acked read
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0C; be = 4'h0;
    @(posedge clk);
    #1;
    chk("midrst_ack_pre", {31'b0, ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", {31'b0, ack}, 32'd0);
    chk("midrst_dat", rdat, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd32(32'h08, q);
    chk("midrst_cmplo", q, 32'hFFFF_FFFF);
    rd32(32'h10, q);
    chk("midrst_ctrl", q, 32'd0);

    // Interrupt: mtimecmp = 100, mtime counts from 0
    wr32(32'h08, 32'd100);
    wr32(32'h0C, 32'd0);
    wr32(32'h10, 32'h3);
    for (int c = 2; c <= 101; c++) begin
      @(negedge clk);
      if (c == 100) chk("tirq_before", {31'b0, tirq}, 32'd0);
      if (c == 101) chk("tirq_rise",   {31'b0, tirq}, 32'd1);
    end
    wr32(32'h08, 32'hFFFF_FFFF);
    chk("tirq_fall", {31'b0, tirq}, 32'd0);

    // Held cyc/stb: ack every other cycle
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; be = 4'h0;
    chk("held_ack0", {31'b0, ack}, 32'd0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("held_ack%0d", c), {31'b0, ack}, 32'(c % 2));
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);

    // cyc dropped right after the accept edge: write still lands
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h08; be = 4'hF; wdat = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("drop_ack", {31'b0, ack}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rd32(32'h08, q);
    chk("drop_write", q, 32'h0BAD_F00D);

`ifdef FAZYRV_TIMER_PRESC_EN
    wr32(32'h10, 32'h0);
    wr32(32'h00, 32'h0);
    wr32(32'h04, 32'h0);
    wr32(32'h14, 32'h3);
    wr32(32'h10, 32'h1);
    repeat (39) @(negedge clk);
    rd32(32'h00, q);
    chk_rng("presc_lo", q, 32'd9, 32'd11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1);
  end

endmodule
